// File: rtl/grid_memory.sv
// Double-buffered Game of Life board memory: row-wise load port, a row sweep that feeds
// an external next-generation calculator, and an atomic bank swap with status flags.
module grid_memory #(
   parameter int  COLS      = 8,
   parameter int  ROWS      = 8,
   parameter int  GEN_WIDTH = 16,
   localparam int AW        = $clog2(ROWS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_run,
   input  logic                 load_we,
   input  logic [AW-1:0]        load_addr,
   input  logic [COLS-1:0]      load_data,
   input  logic                 step_start,
   output logic [COLS-1:0]      row_above,
   output logic [COLS-1:0]      row_cur,
   output logic [COLS-1:0]      row_below,
   input  logic [COLS-1:0]      grid_in,
   output logic                 step_busy,
   output logic                 step_done,
   output logic [GEN_WIDTH-1:0] generation,
   output logic                 stable,
   output logic                 empty,
   input  logic [AW-1:0]        rd_addr,
   output logic [COLS-1:0]      rd_data
);
   localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
   localparam logic [AW:0]   ROWS_W   = (AW + 1)'(ROWS);

   typedef enum logic [1:0] {IDLE, SWEEP, SWAP} state_t;

   state_t          state, next_state;
   logic [COLS-1:0] bank [2][ROWS];
   logic            bank_sel;
   logic [AW-1:0]   r;
   logic [AW-1:0]   above_idx, below_idx;
   logic            changed, any_live;
   logic            start, sweep_wr, swap, load_wr;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Dropping load_run mid-sweep abandons the step; the SWAP cycle is never interrupted.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (step_start && load_run) next_state = SWEEP;
         SWEEP:   if (!load_run)              next_state = IDLE;
                  else if (r == LAST_ROW)     next_state = SWAP;
         SWAP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
   always_comb begin
      step_busy = (state != IDLE);
      start     = (state == IDLE) && step_start && load_run;
      sweep_wr  = (state == SWEEP);
      swap      = (state == SWAP);
      load_wr   = !load_run && load_we && ({1'b0, load_addr} < ROWS_W);
      above_idx = (r == '0)       ? LAST_ROW : r - 1'b1;
      below_idx = (r == LAST_ROW) ? '0       : r + 1'b1;
      row_above = bank[bank_sel][above_idx];
      row_cur   = bank[bank_sel][r];
      row_below = bank[bank_sel][below_idx];
      rd_data   = ({1'b0, rd_addr} < ROWS_W) ? bank[bank_sel][rd_addr] : '0;
   end

   // NOTE: both banks must read as zero straight out of reset, so they are flops with a
   // reset rather than an inferred RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < ROWS; i++)
               bank[b][i] <= '0;
         bank_sel   <= 1'b0;
         r          <= '0;
         changed    <= 1'b0;
         any_live   <= 1'b0;
         generation <= '0;
         stable     <= 1'b0;
         empty      <= 1'b0;
         step_done  <= 1'b0;
      end else begin
         step_done <= swap;
         r         <= (sweep_wr && next_state == SWEEP) ? r + 1'b1 : '0;
         if (sweep_wr) bank[~bank_sel][r]       <= grid_in;
         if (load_wr)  bank[bank_sel][load_addr] <= load_data;
         if (start) begin
            changed  <= 1'b0;
            any_live <= 1'b0;
         end else if (sweep_wr) begin
            changed  <= changed  | (grid_in != row_cur);
            any_live <= any_live | (grid_in != '0);
         end
         if (swap) begin
            bank_sel   <= ~bank_sel;
            generation <= generation + 1'b1;
            stable     <= !changed;
            empty      <= !any_live;
         end
         if (load_wr) begin
            stable <= 1'b0;
            empty  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_grid_memory.sv
// Self-checking bench for grid_memory: the bench plays the life calculator and keeps a
// whole-board reference model of the toroidal Game of Life.
`timescale 1ns/1ps
module tb_grid_memory;
   localparam int COLS      = 8;
   localparam int ROWS      = 6;
   localparam int GEN_WIDTH = 2;
   localparam int AW        = $clog2(ROWS);

   logic                 clk = 1'b0, reset = 1'b0;
   logic                 load_run = 1'b0, load_we = 1'b0, step_start = 1'b0;
   logic [AW-1:0]        load_addr = '0, rd_addr = '0;
   logic [COLS-1:0]      load_data = '0;
   logic [COLS-1:0]      grid_in, row_above, row_cur, row_below, rd_data;
   logic                 step_busy, step_done, stable, empty;
   logic [GEN_WIDTH-1:0] generation;

   int              n_checks = 0, n_fail = 0;
   logic [COLS-1:0] m_board [ROWS];
   int              m_gen = 0;
   bit              m_stable = 1'b0, m_empty = 1'b0;
   logic [COLS-1:0] seen_above0, seen_below_last;

   grid_memory #(.COLS(COLS), .ROWS(ROWS), .GEN_WIDTH(GEN_WIDTH)) dut (
      .clk(clk), .reset(reset), .load_run(load_run), .load_we(load_we),
      .load_addr(load_addr), .load_data(load_data), .step_start(step_start),
      .row_above(row_above), .row_cur(row_cur), .row_below(row_below),
      .grid_in(grid_in), .step_busy(step_busy), .step_done(step_done),
      .generation(generation), .stable(stable), .empty(empty),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #10 clk = ~clk;

   function automatic bit rule(input bit alive, input int n);
      return alive ? (n == 2 || n == 3) : (n == 3);
   endfunction

   // Calculator: next value of the middle row from a three-row window, columns wrap.
   function automatic logic [COLS-1:0] calc_row(input logic [COLS-1:0] a, c, b);
      logic [COLS-1:0] res;
      int n, k;
      res = '0;
      for (int j = 0; j < COLS; j++) begin
         n = 0;
         for (int dj = -1; dj <= 1; dj++) begin
            k = (j + dj + COLS) % COLS;
            n += int'(a[k]) + int'(b[k]) + ((dj != 0) ? int'(c[k]) : 0);
         end
         res[j] = rule(c[j], n);
      end
      return res;
   endfunction

   always_comb grid_in = calc_row(row_above, row_cur, row_below);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Whole-board reference step on the torus.
   task automatic model_step();
      logic [COLS-1:0] nxt [ROWS];
      int n;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) begin
            n = 0;
            for (int di = -1; di <= 1; di++)
               for (int dj = -1; dj <= 1; dj++)
                  if (di != 0 || dj != 0)
                     n += int'(m_board[(i + di + ROWS) % ROWS][(j + dj + COLS) % COLS]);
            nxt[i][j] = rule(m_board[i][j], n);
         end
      m_stable = 1'b1;
      m_empty  = 1'b1;
      for (int i = 0; i < ROWS; i++) begin
         if (nxt[i] != m_board[i]) m_stable = 1'b0;
         if (nxt[i] != '0)         m_empty  = 1'b0;
         m_board[i] = nxt[i];
      end
      m_gen = (m_gen + 1) % (1 << GEN_WIDTH);
   endtask

   task automatic check_board();
      for (int i = 0; i < ROWS; i++) begin
         rd_addr = AW'(i);
         #1;
         check($sformatf("rd_row%0d", i), rd_data, m_board[i]);
      end
      check("generation", generation, m_gen);
      check("stable", stable, m_stable);
      check("empty", empty, m_empty);
   endtask

   task automatic load_row(input int addr, input logic [COLS-1:0] data);
      load_run  = 1'b0;
      load_we   = 1'b1;
      load_addr = AW'(addr);
      load_data = data;
      tick();
      load_we   = 1'b0;
      if (addr < ROWS) m_board[addr] = data;
      m_stable = 1'b0;
      m_empty  = 1'b0;
   endtask

   task automatic clear_board();
      for (int i = 0; i < ROWS; i++) load_row(i, '0);
   endtask

   task automatic run_step();
      int n;
      load_run   = 1'b1;
      step_start = 1'b1;
      tick();
      step_start = 1'b0;
      check("busy_at_start", step_busy, 1);
      seen_above0 = row_above;
      n = 0;
      while (!step_done && n < 4 * ROWS) begin
         if (n == ROWS - 1) seen_below_last = row_below;
         tick();
         n++;
      end
      check("step_latency", n, ROWS + 1);
      check("busy_after_done", step_busy, 0);
      model_step();
      check_board();
      tick();
      check("done_one_cycle", step_done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_cnt, prev_gen;
      for (int i = 0; i < ROWS; i++) m_board[i] = '0;

      // Reset state
      tick(); tick();
      check("rst_busy", step_busy, 0);
      check("rst_done", step_done, 0);
      check("rst_row_cur", row_cur, 0);
      check_board();
      reset = 1'b1;
      tick();

      // Load and readback, including out-of-range rows
      for (int i = 0; i < ROWS; i++) load_row(i, 8'h01 << i);
      load_row(6, 8'hFF);
      load_row(7, 8'hFF);
      check_board();
      rd_addr = AW'(6); #1; check("rd_oob6", rd_data, 0);
      rd_addr = AW'(7); #1; check("rd_oob7", rd_data, 0);

      // Blinker oscillates with period two
      clear_board();
      for (int i = 1; i <= 3; i++) load_row(i, 8'h04);
      run_step();
      rd_addr = AW'(2); #1; check("blinker_row2", rd_data, 8'h0E);
      run_step();
      rd_addr = AW'(2); #1; check("blinker_back", rd_data, 8'h04);

      // Toroidal neighbours during the sweep
      clear_board();
      load_row(0, 8'h01);
      load_row(ROWS - 1, 8'h80);
      run_step();
      check("wrap_above_r0", seen_above0, 8'h80);
      check("wrap_below_last", seen_below_last, 8'h01);

      // Block straddling both wraps is a still life
      clear_board();
      load_row(0, 8'h81);
      load_row(ROWS - 1, 8'h81);
      run_step();
      check("block_stable", stable, 1);

      // Abort by dropping load_run on the third sweep cycle
      for (int i = 0; i < ROWS; i++) load_row(i, COLS'($urandom));
      load_run = 1'b1; step_start = 1'b1;
      tick();
      step_start = 1'b0;
      tick(); tick();
      load_run = 1'b0;
      tick();
      check("abort_idle", step_busy, 0);
      done_cnt = 0;
      repeat (ROWS + 3) begin tick(); done_cnt += int'(step_done); end
      check("abort_no_done", done_cnt, 0);
      check_board();

      // step_start held while busy yields exactly one generation
      load_run = 1'b1; step_start = 1'b1; done_cnt = 0;
      repeat (ROWS + 2) begin tick(); done_cnt += int'(step_done); end
      step_start = 1'b0;
      repeat (ROWS + 3) begin tick(); done_cnt += int'(step_done); end
      check("busy_single_step", done_cnt, 1);
      model_step();
      check_board();

      // load_we ignored in run mode
      load_run = 1'b1; load_we = 1'b1; load_addr = '0; load_data = ~m_board[0];
      tick();
      load_we = 1'b0;
      check_board();

      // Extinction, stability and generation wrap
      clear_board();
      load_row(3, 8'h10);
      run_step();
      check("extinct_empty", empty, 1);
      check("extinct_not_stable", stable, 0);
      run_step();
      check("dead_stable", stable, 1);
      repeat (4) begin
         prev_gen = m_gen;
         run_step();
         if (prev_gen == 3) check("gen_wrap", generation, 0);
      end

      // Random boards against the model
      repeat (6) begin
         for (int i = 0; i < ROWS; i++) load_row(i, COLS'($urandom));
         check_board();
         run_step();
         run_step();
      end

      // Asynchronous reset in the middle of a sweep
      load_row(0, 8'hFF);
      load_run = 1'b1; step_start = 1'b1;
      tick();
      step_start = 1'b0;
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", step_busy, 0);
      check("midrst_gen", generation, 0);
      for (int i = 0; i < ROWS; i++) m_board[i] = '0;
      m_gen = 0; m_stable = 1'b0; m_empty = 1'b0;
      check_board();
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_idle", step_busy, 0);
      run_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/grid_memory.md
# grid_memory

Parametrised, double-buffered Game of Life board memory holding a ROWS x COLS grid as ROWS row words. The next-generation calculator is combinational and sits outside this block. In load mode the board is written row by row from the external interface. In run mode, each step request sweeps every row: the block presents the row plus its toroidal neighbours, captures the calculator's next-row result into a shadow bank, then swaps banks atomically and reports generation count, stability and extinction.

## Interface

Parameters:
- COLS, 8: cells per row (row word width); COLS >= 3.
- ROWS, 8: rows in the board; ROWS >= 3.
- GEN_WIDTH, 16: generation counter width.

Ports (AW = $clog2(ROWS)):
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- load_run, input, 1, 0 = load mode, 1 = run mode.
- load_we, input, 1, load-mode row write enable.
- load_addr, input, AW, row index for load writes.
- load_data, input, COLS, row value for load writes.
- step_start, input, 1, request one generation step.
- row_above, output, COLS, active-bank row (r-1) mod ROWS.
- row_cur, output, COLS, active-bank row r.
- row_below, output, COLS, active-bank row (r+1) mod ROWS.
- grid_in, input, COLS, calculator's next-generation value for row r.
- step_busy, output, 1, a step is in progress.
- step_done, output, 1, one-cycle pulse when the new generation becomes active.
- generation, output, GEN_WIDTH, completed-step count.
- stable, output, 1, last step changed no cell.
- empty, output, 1, last step produced an all-zero board.
- rd_addr, input, AW, display read row index.
- rd_data, output, COLS, active-bank row rd_addr, combinational.

## Operation

- Storage: two banks of ROWS x COLS bits, plus bank_sel naming the active bank.
- FSM states:
  - IDLE -> SWEEP on step_start && load_run; row counter r is cleared to 0.
  - SWEEP: each cycle writes grid_in into shadow[r].
    - r < ROWS-1: r increments.
    - r == ROWS-1: go to SWAP.
  - SWAP: toggle bank_sel; generation += 1, wrapping modulo 2^GEN_WIDTH; update stable/empty; pulse step_done; return to IDLE.
- Row outputs:
  - During SWEEP they reflect r, with wrap: row_above at r=0 is row ROWS-1; row_below at r=ROWS-1 is row 0.
  - In IDLE/SWAP, r is held at 0.
- stable: while sweeping, track changed |= (grid_in != active[r]); at SWAP, stable = !changed.
- empty: while sweeping, track any |= (grid_in != 0); at SWAP, empty = !any.
- Load writes (load_run=0 && load_we):
  - Write load_data to active[load_addr].
  - Clear stable and empty.
  - Leave generation unchanged.
- load_addr >= ROWS (non-power-of-two ROWS): the write is ignored. rd_addr >= ROWS reads 0.
- Priority and abort:
  - step_start is ignored while step_busy or while load_run=0.
  - load_we is ignored while load_run=1.
  - load_run falling during SWEEP aborts: next state IDLE, bank_sel unchanged, shadow contents don't-care, no step_done, generation/stable/empty unchanged.
  - load_run falling in the SWAP cycle does not abort; the swap completes.
- Reset (reset=0, asynchronous):
  - Both banks cleared; bank_sel=0; r=0; state IDLE.
  - generation=0, step_busy=0, step_done=0, stable=0, empty=0; row outputs and rd_data read 0.

## Timing

- step_start is sampled at edge E0 (in IDLE, load_run=1).
- SWEEP covers cycles after edges E0 .. E0+ROWS-1. Row r is presented in the cycle after edge E0+r and written at edge E0+r+1.
- SWAP is the cycle after edge E0+ROWS. bank_sel toggles at edge E0+ROWS+1.
- step_done, new generation, stable and empty are visible after edge E0+ROWS+1 for exactly one cycle (step_done) or until next update (others).
- step_busy is high from after E0 until edge E0+ROWS+1, i.e. ROWS+1 cycles.
- A new step_start is accepted at edge E0+ROWS+2 at the earliest; back-to-back steps take ROWS+2 cycles per generation.
- rd_data is combinational from the active bank. It shows the old generation throughout SWEEP/SWAP and the new one from edge E0+ROWS+1.
- A load write at edge E is visible on rd_data after E.

## Test plan

- Reset: drive reset=0 mid-sweep with a nonzero board -> immediately generation=0, step_busy=0, all rd_data rows 0; after release, IDLE.
- Load/readback: COLS=8, ROWS=8; write rows 0..7 with 8'h01<<i -> rd_data(i)=8'h01<<i; generation=0; stable=0.
- Blinker: 5x5, rows 1,2,3 = 5'b00100, bench models life rule; step -> after exactly 6 cycles step_done, rows 2 = 5'b01110, others 0, generation=1, stable=0; second step restores original, generation=2.
- Toroidal wrap: row 0 = 8'h01, row 7 = 8'h80; during r=0 row_above=8'h80, during r=7 row_below=8'h01; block stays fixed (stable=1) after step.
- Abort/priority: drop load_run at 3rd SWEEP cycle -> no step_done, generation unchanged, board unchanged; step_start while busy ignored (exactly one increment); load_we in run mode no write.
- Counter/extinction: GEN_WIDTH=2, single live cell -> after step empty=1, stable=0; next step stable=1; after 4 steps generation wraps 3->0.
